// File: rtl/rob.sv
// Reorder buffer: in-order retirement of out-of-order results. Optional flush port via ROB_FLUSH_EN.
// Latency: writeback to commit is 1 cycle (done registered), commit is combinational off head state.
// Backpressure: alloc_ready_o drops when full (registered state only); commit side never stalls.
//
// Ports: clk_i/reset_i (sync, active-high); alloc_* dispatch handshake returning alloc_tag_o;
// wb_* result writeback by tag; commit_* retirement to the regfile; empty_o/count_o occupancy.
// `define ROB_FLUSH_EN adds flush_i, which clears all state like reset.
module rob #(
    parameter int ROB_DEPTH = 8,
    parameter int DATA_W    = 32,
    localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
`ifdef ROB_FLUSH_EN
    input  logic              flush_i,
`endif
    input  logic              alloc_valid_i,
    input  logic [4:0]        alloc_rd_addr_i,
    input  logic [DATA_W-1:0] alloc_pc_i,
    output logic              alloc_ready_o,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              wb_valid_i,
    input  logic [TAG_W-1:0]  wb_tag_i,
    input  logic [DATA_W-1:0] wb_value_i,
    output logic              commit_valid_o,
    output logic [4:0]        commit_rd_addr_o,
    output logic [DATA_W-1:0] commit_value_o,
    output logic [DATA_W-1:0] commit_pc_o,
    output logic              empty_o,
    output logic [TAG_W:0]    count_o
);

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] value;
    } entry_t;

    entry_t               entry_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] busy_q;
    logic [ROB_DEPTH-1:0] done_q;

    // Pointers carry one extra wrap bit above the index.
    logic [TAG_W:0]   head_q;
    logic [TAG_W:0]   tail_q;
    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             alloc_fire;
    logic             clear_all;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

    assign count_o       = tail_q - head_q;
    assign empty_o       = (head_q == tail_q);
    assign alloc_ready_o = !full;
    assign alloc_tag_o   = tail_idx;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

`ifdef ROB_FLUSH_EN
    assign clear_all      = reset_i || flush_i;
    assign commit_valid_o = busy_q[head_idx] && done_q[head_idx] && !flush_i;
`else
    assign clear_all      = reset_i;
    assign commit_valid_o = busy_q[head_idx] && done_q[head_idx];
`endif

    assign commit_rd_addr_o = commit_valid_o ? entry_q[head_idx].rd    : '0;
    assign commit_value_o   = commit_valid_o ? entry_q[head_idx].value : '0;
    assign commit_pc_o      = commit_valid_o ? entry_q[head_idx].pc    : '0;

    always_ff @(posedge clk_i) begin
        if (clear_all) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            // Allocation only fires when not full, so tail never aliases a committing head.
            if (alloc_fire) begin
                entry_q[tail_idx] <= '{rd: alloc_rd_addr_i, pc: alloc_pc_i, value: '0};
                busy_q[tail_idx]  <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + 1'b1;
            end
            // Stale or stray results for free slots are dropped.
            if (wb_valid_i && busy_q[wb_tag_i]) begin
                entry_q[wb_tag_i].value <= wb_value_i;
                done_q[wb_tag_i]        <= 1'b1;
            end
            // Placed last so a retiring entry is freed even if it also sees a writeback.
            if (commit_valid_o) begin
                busy_q[head_idx] <= 1'b0;
                done_q[head_idx] <= 1'b0;
                head_q           <= head_q + 1'b1;
            end
        end
    end

endmodule
